condition_unit: RTL and testbench
=================================

Name: condition_unit

Overview:
- Parametrised successor to the combinational condition decoder.
- Owns the architectural flags register {N,Z,C,V}, which has a one-entry shadow for interrupt entry and return.
- Evaluates CHANNELS condition selects in parallel against the flags, with optional same-cycle forwarding of a flags write.
- The result is registered as a one-stage pipeline with stall and flush. It sits between the ALU flag output and the execute/branch stage.

Parameters:
- CHANNELS, 2: number of independent condition evaluations per cycle (1..8).
- COND_WIDTH, 4: select width. 3 gives the legacy signed set only; 4 adds the unsigned/flag-test set.
- FORWARD, 1: 1 means evaluation uses flags_in when flags_we is high in the same cycle; 0 means it always uses the registered flags.

Ports:
- clock  in  1  system clock; all state updates on its rising edge
- reset  in  1  synchronous, active-high reset
- flags_we  in  1  write flags_in into the flags register
- flags_in  in  4  new flags, bit order {N,Z,C,V} = [3:0]
- flags_save  in  1  copy the flags register into the shadow
- flags_restore  in  1  load the flags register from the shadow
- flags_out  out  4  current flags register
- stall  in  1  hold the output stage
- flush  in  1  invalidate the output stage
- cond_valid_in  in  CHANNELS  per-channel request valid
- cond_select_in  in  CHANNELS*COND_WIDTH  channel k occupies bits [k*COND_WIDTH +: COND_WIDTH]
- cond_valid_out  out  CHANNELS  registered per-channel valid
- cond_satisfied_out  out  CHANNELS  registered per-channel result; qualified by cond_valid_out

Behaviour:
- Reset (synchronous, active-high):
  - flags register = 0 and shadow = 0.
  - cond_valid_out = 0 and cond_satisfied_out = 0.
  - Reset overrides every other input.
- Flags register next-state, in priority order:
  1. reset
  2. flags_restore (shadow -> flags; flags_we that cycle is ignored)
  3. flags_we (flags_in -> flags)
  4. otherwise hold
- Flags register ignores stall and flush.
- Shadow:
  - Loaded from the pre-edge flags register when flags_save = 1.
  - Save together with flags_we: the shadow gets the old value, the register gets flags_in.
  - Save together with restore: swap.
- Evaluation flags E:
  - E = flags_in when FORWARD = 1, flags_we = 1 and flags_restore = 0.
  - Otherwise E = the flags register.
- Condition encodings:
  - 3-bit legacy set:
    - 0 EQ: Z
    - 1 NE: !Z
    - 2 GT: !Z & (N==V)
    - 3 GE: N==V
    - 4 LT: N!=V
    - 5 LE: Z | (N!=V)
    - 6 NV: 0
    - 7 AL: 1
  - Added when COND_WIDTH = 4:
    - 8 HI: C & !Z
    - 9 HS: C
    - 10 LO: !C
    - 11 LS: !C | Z
    - 12 MI: N
    - 13 PL: !N
    - 14 VS: V
    - 15 VC: !V
  - C is the not-borrow carry.
  - When COND_WIDTH = 3, codes 8-15 are unreachable.
- Output stage, latency 1 cycle:
  - flush = 1: cond_valid_out <= 0. Flush beats stall. cond_satisfied_out holds.
  - Else stall = 1: both outputs hold. Upstream must keep its inputs stable.
  - Else: cond_valid_out <= cond_valid_in.
  - Else, per channel: cond_satisfied_out[k] <= cond_valid_in[k] ? eval(sel_k, E) : 0.
- Channels are fully independent. Identical selects give identical results.
- Reset mid-stall clears the outputs. Stall stays asserted afterwards with valid = 0.

Decomposition:
- Shared package (instructions header): condition code constants for EQ..AL (0-7) and HI..VC (8-15), and flag bit index constants FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0.
- One combinational sub-module, condition_eval, parameter COND_WIDTH: inputs select and the 4 flags, output satisfied. It is instantiated CHANNELS times in a generate loop.
- Flags register, shadow and output pipeline stay in condition_unit.

Test Plan:
- Reset, then flags_we=1, flags_in=4'b0100 (Z) -> flags_out=4'b0100 next cycle. Ch0 sel=0 (EQ) valid -> cond_satisfied_out[0]=1 and cond_valid_out[0]=1 one cycle later.
- FORWARD=1, flags register = 0, same cycle flags_we=1, flags_in=4'b1000 (N), ch0 sel=4 (LT), ch1 sel=3 (GE) -> outputs 1 and 0. With FORWARD=0 the same stimulus gives 0 and 1.
- COND_WIDTH=4, flags=4'b0010 (C) -> sel 8,9,10,11 give 1,1,0,0. With flags=4'b0110 -> 0,1,0,1.
- flags=4'b1001, flags_save; then flags_we 4'b0100; then flags_restore together with flags_we 4'b1111 -> flags_out=4'b1001 (restore wins).
- Valid result latched, stall=1 for 3 cycles while cond_select_in changes -> outputs unchanged. Then flush=1 with stall=1 -> cond_valid_out=0 next cycle.
- Reset asserted while stall=1 and cond_valid_out=2'b11 -> next cycle flags_out=0 and cond_valid_out=0. Sel 6 (NV) gives 0 and sel 7 (AL) gives 1 regardless of flags.

Source files
------------

// File: rtl/condition_unit_pkg.sv
// Shared constants for the condition unit.
// Condition select codes and flag bit positions within {N,Z,C,V}.
package condition_unit_pkg;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  localparam logic [3:0] COND_EQ = 4'd0;
  localparam logic [3:0] COND_NE = 4'd1;
  localparam logic [3:0] COND_GT = 4'd2;
  localparam logic [3:0] COND_GE = 4'd3;
  localparam logic [3:0] COND_LT = 4'd4;
  localparam logic [3:0] COND_LE = 4'd5;
  localparam logic [3:0] COND_NV = 4'd6;
  localparam logic [3:0] COND_AL = 4'd7;
  localparam logic [3:0] COND_HI = 4'd8;
  localparam logic [3:0] COND_HS = 4'd9;
  localparam logic [3:0] COND_LO = 4'd10;
  localparam logic [3:0] COND_LS = 4'd11;
  localparam logic [3:0] COND_MI = 4'd12;
  localparam logic [3:0] COND_PL = 4'd13;
  localparam logic [3:0] COND_VS = 4'd14;
  localparam logic [3:0] COND_VC = 4'd15;

endpackage

// File: rtl/condition_eval.sv
// Combinational evaluation of one condition select against {N,Z,C,V}.
// Ports: select (COND_WIDTH), flags (4), satisfied (1).
module condition_eval
  import condition_unit_pkg::*;
#(
  parameter int COND_WIDTH = 4
) (
  input  logic [COND_WIDTH-1:0] select,
  input  logic [3:0]            flags,
  output logic                  satisfied
);

  logic [3:0] sel4;
  logic       n, z, c, v;

  // Zero-extension makes codes 8-15 unreachable at width 3.
  assign sel4 = 4'(select);
  assign n = flags[FLAG_N];
  assign z = flags[FLAG_Z];
  assign c = flags[FLAG_C];
  assign v = flags[FLAG_V];

  always_comb begin
    satisfied = 1'b0;
    unique case (sel4)
      COND_EQ: satisfied = z;
      COND_NE: satisfied = !z;
      COND_GT: satisfied = !z && (n == v);
      COND_GE: satisfied = (n == v);
      COND_LT: satisfied = (n != v);
      COND_LE: satisfied = z || (n != v);
      COND_NV: satisfied = 1'b0;
      COND_AL: satisfied = 1'b1;
      // C is the not-borrow carry.
      COND_HI: satisfied = c && !z;
      COND_HS: satisfied = c;
      COND_LO: satisfied = !c;
      COND_LS: satisfied = !c || z;
      COND_MI: satisfied = n;
      COND_PL: satisfied = !n;
      COND_VS: satisfied = v;
      COND_VC: satisfied = !v;
    endcase
  end

endmodule

// File: rtl/condition_unit.sv
// Flags register with shadow, parallel condition evaluation, 1-cycle output stage.
// Ports: clock/reset, flags write/save/restore, stall/flush, per-channel cond in/out.
module condition_unit
  import condition_unit_pkg::*;
#(
  parameter int CHANNELS   = 2,
  parameter int COND_WIDTH = 4,
  parameter int FORWARD    = 1
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           flags_we,
  input  logic [3:0]                     flags_in,
  input  logic                           flags_save,
  input  logic                           flags_restore,
  output logic [3:0]                     flags_out,
  input  logic                           stall,
  input  logic                           flush,
  input  logic [CHANNELS-1:0]            cond_valid_in,
  input  logic [CHANNELS*COND_WIDTH-1:0] cond_select_in,
  output logic [CHANNELS-1:0]            cond_valid_out,
  output logic [CHANNELS-1:0]            cond_satisfied_out
);

  logic [3:0]          flags_q;
  logic [3:0]          shadow_q;
  logic [3:0]          eval_flags;
  logic                fwd;
  logic [CHANNELS-1:0] eval_sat;
  logic [CHANNELS-1:0] valid_q;
  logic [CHANNELS-1:0] sat_q;

  // Restore wins over a write, so a restore cycle never forwards.
  assign fwd = (FORWARD != 0) && flags_we && !flags_restore;
  assign eval_flags = fwd ? flags_in : flags_q;

  // Save samples the pre-edge register: save+restore swaps.
  always_ff @(posedge clock) begin
    if (reset) begin
      flags_q  <= 4'b0;
      shadow_q <= 4'b0;
    end else begin
      if (flags_restore) flags_q <= shadow_q;
      else if (flags_we) flags_q <= flags_in;
      if (flags_save) shadow_q <= flags_q;
    end
  end

  for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
    condition_eval #(
      .COND_WIDTH(COND_WIDTH)
    ) u_eval (
      .select   (cond_select_in[k*COND_WIDTH +: COND_WIDTH]),
      .flags    (eval_flags),
      .satisfied(eval_sat[k])
    );
  end

  // Flush clears valid only; the result bits keep their last value.
  always_ff @(posedge clock) begin
    if (reset) begin
      valid_q <= '0;
      sat_q   <= '0;
    end else if (flush) begin
      valid_q <= '0;
    end else if (!stall) begin
      valid_q <= cond_valid_in;
      sat_q   <= cond_valid_in & eval_sat;
    end
  end

  assign flags_out          = flags_q;
  assign cond_valid_out     = valid_q;
  assign cond_satisfied_out = sat_q;

endmodule

// File: tb/tb_condition_unit.sv
// Scoreboard bench for condition_unit: FORWARD=1 and FORWARD=0 instances share stimulus.
// Expected {valid,satisfied} pairs are queued at issue and popped by a monitor.
module tb_condition_unit;
  import condition_unit_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       flags_we = 1'b0;
  logic [3:0] flags_in = 4'b0;
  logic       flags_save = 1'b0;
  logic       flags_restore = 1'b0;
  logic       stall = 1'b0;
  logic       flush = 1'b0;
  logic [1:0] cv_in = 2'b0;
  logic [7:0] sel_in = 8'b0;

  logic [3:0] f_out, f_out_nf;
  logic [1:0] v_out, v_out_nf;
  logic [1:0] s_out, s_out_nf;

  int tests = 0;
  int fails = 0;

  logic [3:0] q[$];
  logic [3:0] q_nf[$];
  logic load_q = 1'b0;

  always #5 clk = ~clk;

  condition_unit #(
    .CHANNELS(2), .COND_WIDTH(4), .FORWARD(1)
  ) dut (
    .clock(clk), .reset(reset),
    .flags_we(flags_we), .flags_in(flags_in),
    .flags_save(flags_save), .flags_restore(flags_restore),
    .flags_out(f_out), .stall(stall), .flush(flush),
    .cond_valid_in(cv_in), .cond_select_in(sel_in),
    .cond_valid_out(v_out), .cond_satisfied_out(s_out)
  );

  condition_unit #(
    .CHANNELS(2), .COND_WIDTH(4), .FORWARD(0)
  ) dut_nf (
    .clock(clk), .reset(reset),
    .flags_we(flags_we), .flags_in(flags_in),
    .flags_save(flags_save), .flags_restore(flags_restore),
    .flags_out(f_out_nf), .stall(stall), .flush(flush),
    .cond_valid_in(cv_in), .cond_select_in(sel_in),
    .cond_valid_out(v_out_nf), .cond_satisfied_out(s_out_nf)
  );

  task automatic chk(input string name, input logic [3:0] act,
                     input logic [3:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // A new result is presented one edge after an unstalled, unflushed issue.
  always @(posedge clk)
    load_q <= !reset && !flush && !stall && (cv_in != 2'b0);

  always @(negedge clk) begin
    if (load_q) begin
      if (q.size() == 0) begin
        chk("fwd_sb_empty", 4'd1, 4'd0);
      end else begin
        chk("fwd_result", {v_out, s_out}, q.pop_front());
      end
      if (q_nf.size() == 0) begin
        chk("nofwd_sb_empty", 4'd1, 4'd0);
      end else begin
        chk("nofwd_result", {v_out_nf, s_out_nf}, q_nf.pop_front());
      end
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic idle();
    flags_we = 1'b0; flags_save = 1'b0; flags_restore = 1'b0;
    stall = 1'b0; flush = 1'b0; cv_in = 2'b0;
  endtask

  task automatic issue(input logic [1:0] v, input logic [3:0] s0,
                       input logic [3:0] s1, input logic [1:0] es,
                       input logic [1:0] es_nf);
    cv_in = v;
    sel_in = {s1, s0};
    q.push_back({v, es});
    q_nf.push_back({v, es_nf});
  endtask

  task automatic wr_flags(input logic [3:0] f);
    flags_we = 1'b1; flags_in = f;
    step();
    idle();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    step(); step();
    reset = 1'b0;
    idle();
    chk("reset_flags", f_out, 4'b0);
    chk("reset_valid", {2'b0, v_out}, 4'b0);
    chk("reset_sat", {2'b0, s_out}, 4'b0);

    // Write Z while issuing EQ: forwarded on one, not on the other.
    flags_we = 1'b1; flags_in = 4'b0100;
    issue(2'b01, COND_EQ, COND_EQ, 2'b01, 2'b00);
    step(); idle();
    chk("flags_z", f_out, 4'b0100);
    issue(2'b01, COND_EQ, COND_EQ, 2'b01, 2'b01);
    step(); idle();

    // Forward N: LT/GE read flags_in vs registered zero.
    wr_flags(4'b0000);
    flags_we = 1'b1; flags_in = 4'b1000;
    issue(2'b11, COND_LT, COND_GE, 2'b01, 2'b10);
    step(); idle();

    // Unsigned set with C, then with C|Z.
    wr_flags(4'b0010);
    issue(2'b11, COND_HI, COND_HS, 2'b11, 2'b11);
    step();
    issue(2'b11, COND_LO, COND_LS, 2'b00, 2'b00);
    step(); idle();
    wr_flags(4'b0110);
    issue(2'b11, COND_HI, COND_HS, 2'b10, 2'b10);
    step();
    issue(2'b11, COND_LO, COND_LS, 2'b10, 2'b10);
    step();
    issue(2'b10, COND_AL, COND_EQ, 2'b10, 2'b10);
    step(); idle();

    // Shadow save, overwrite, restore beats write.
    wr_flags(4'b1001);
    chk("flags_1001", f_out, 4'b1001);
    flags_save = 1'b1;
    step(); idle();
    wr_flags(4'b0100);
    chk("flags_after_we", f_out, 4'b0100);
    flags_restore = 1'b1; flags_we = 1'b1; flags_in = 4'b1111;
    issue(2'b01, COND_MI, COND_MI, 2'b00, 2'b00);
    step(); idle();
    chk("restore_wins", f_out, 4'b1001);

    // Save together with restore swaps.
    wr_flags(4'b0011);
    flags_save = 1'b1; flags_restore = 1'b1;
    step(); idle();
    chk("swap_flags", f_out, 4'b1001);
    flags_restore = 1'b1;
    step(); idle();
    chk("swap_back", f_out, 4'b0011);

    // Stall holds, flush beats stall and keeps satisfied.
    issue(2'b11, COND_AL, COND_VS, 2'b11, 2'b11);
    step(); idle();
    stall = 1'b1; cv_in = 2'b11;
    for (int i = 0; i < 3; i++) begin
      sel_in = {COND_NV, 4'(i)};
      step();
      chk("stall_hold", {v_out, s_out}, 4'b1111);
    end
    flush = 1'b1;
    step();
    chk("flush_valid", {v_out, s_out}, 4'b0011);
    idle();

    // Reset while stalled clears everything, even with a write.
    issue(2'b11, COND_NV, COND_AL, 2'b10, 2'b10);
    step(); idle();
    stall = 1'b1; reset = 1'b1;
    flags_we = 1'b1; flags_in = 4'b1111; cv_in = 2'b11;
    step();
    reset = 1'b0; flags_we = 1'b0;
    chk("rst_stall_flags", f_out, 4'b0);
    chk("rst_stall_out", {v_out, s_out}, 4'b0);
    step();
    chk("stall_after_rst", {v_out, s_out}, 4'b0);
    idle();

    // NV/AL regardless of flags; signed and flag tests on zero.
    wr_flags(4'b1111);
    issue(2'b11, COND_NV, COND_AL, 2'b10, 2'b10);
    step(); idle();
    wr_flags(4'b0000);
    issue(2'b11, COND_GT, COND_LE, 2'b01, 2'b01);
    step();
    issue(2'b11, COND_NE, COND_PL, 2'b11, 2'b11);
    step();
    issue(2'b11, COND_VC, COND_NV, 2'b01, 2'b01);
    step(); idle();
    step(); step();

    chk("sb_drained", 4'(q.size() + q_nf.size()), 4'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
